// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with an input FIFO and a valid/ready handshake.
// Frames are start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int W5Frequency = 6_250_000,
  parameter int baudRate    = 230400,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic                               TxD,
  input  logic                               tx_valid,
  input  logic [DATA_BITS-1:0]               tx_data,
  output logic                               tx_ready,
  output logic                               isBusy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int BIT_TICKS  = W5Frequency / baudRate;
  localparam int STOP_TICKS = STOP_BITS * BIT_TICKS;
  localparam int TICK_W     = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
  localparam int BIT_W      = $clog2(DATA_BITS);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end
    if (BIT_TICKS < 1) begin : g_bad_baud
      $error("uart_tx_fifo: W5Frequency must be at least baudRate");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------- input FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push, pop;

  assign tx_ready   = (count != CNT_W'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count;

  // NOTE: the storage array has no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- frame sequencer ----------------
  state_t               state, state_d;
  logic [TICK_W-1:0]    tick, tick_d;
  logic [BIT_W-1:0]     bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par, par_d;
  logic                 txd_q, txd_d;
  logic                 load;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 bit_done, stop_done;

  assign head      = mem[rd_ptr];
  assign head_par  = (PARITY_MODE == 2) ? ~(^head) : ^head;
  assign bit_done  = (tick == TICK_W'(BIT_TICKS - 1));
  assign stop_done = (tick == TICK_W'(STOP_TICKS - 1));

  // NOTE: every output of this block is given a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state;
    tick_d    = tick + TICK_W'(1);
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    par_d     = par;
    txd_d     = txd_q;
    load      = 1'b0;
    case (state)
      IDLE: begin
        tick_d = '0;
        txd_d  = 1'b1;
        load   = (count != '0);
      end
      START: begin
        if (bit_done) begin
          tick_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          txd_d     = shreg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          tick_d  = '0;
          shreg_d = shreg >> 1;
          if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            if (PARITY_MODE != 0) begin
              state_d = PARITY;
              txd_d   = par;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx + BIT_W'(1);
            txd_d     = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          tick_d  = '0;
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        if (stop_done) begin
          tick_d = '0;
          if (count != '0) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
    // Popping the head starts the next frame on this same edge, which gives back-to-back frames.
    if (load) begin
      shreg_d   = head;
      par_d     = head_par;
      bit_idx_d = '0;
      tick_d    = '0;
      state_d   = START;
      txd_d     = 1'b0;
    end
  end

  assign pop = load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state   <= state_d;
      tick    <= tick_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      par     <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign TxD    = txd_q;
  assign isBusy = (state != IDLE) || (count != '0);

endmodule
